// File: rtl/ws2812_pkg.sv
// ----------------------------------------------------------------------------
// ws2812_pkg
// Shared definitions for the WS2812 stream encoder:
//   - ws_state_e : encoder state (LATCH, IDLE, SEND)
//   - DEF_*      : default bit timing for a 50 MHz clock
//   - cnt_width  : register width needed to hold 0..max_count-1 (never 0)
// ----------------------------------------------------------------------------
package ws2812_pkg;

   typedef enum logic [1:0] {
      LATCH = 2'd0,
      IDLE  = 2'd1,
      SEND  = 2'd2
   } ws_state_e;

   localparam int DEF_BITS    = 24;
   localparam int DEF_T_BIT   = 63;
   localparam int DEF_T0H     = 15;
   localparam int DEF_T1H     = 45;
   localparam int DEF_T_RESET = 15000;

   // Width of a counter running 0..max_count-1; a one-value counter still gets one bit.
   function automatic int cnt_width(input int max_count);
      return (max_count > 1) ? $clog2(max_count) : 1;
   endfunction

endpackage

// File: rtl/ws2812_stream_tx_rz_bit_timer.sv
// ----------------------------------------------------------------------------
// rz_bit_timer
// Bit-cell counter for the RZ encoder. While run is high the counter steps
// 0..T_BIT-1 and wraps; while run is low it parks at 0 so the next cell
// always starts from a clean count.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   run         : a bit cell is in progress this cycle
//   bit_val     : value of the bit being sent (selects T1H or T0H)
//   cell_end    : counter is at the last cycle of the cell
//   level       : line level for the current count (pre-inversion)
// ----------------------------------------------------------------------------
module rz_bit_timer
   import ws2812_pkg::*;
#(
   parameter int T_BIT = DEF_T_BIT,
   parameter int T0H   = DEF_T0H,
   parameter int T1H   = DEF_T1H
)(
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic bit_val,
   output logic cell_end,
   output logic level
);

   localparam int CNT_W = cnt_width(T_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_BIT - 1);
   localparam logic [CNT_W-1:0] HIGH_0   = CNT_W'(T0H);
   localparam logic [CNT_W-1:0] HIGH_1   = CNT_W'(T1H);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nx_s;

   // Next count: advance inside a running cell, wrap at its end, park at zero otherwise.
   always_comb begin
      cnt_nx_s = '0;
      if (run) begin
         if (cnt_r == CNT_LAST) begin
            cnt_nx_s = '0;
         end else begin
            cnt_nx_s = cnt_r + CNT_W'(1);
         end
      end else begin
         cnt_nx_s = '0;
      end
   end

   // Cell counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_nx_s;
      end
   end

   assign cell_end = (cnt_r == CNT_LAST);
   assign level    = (cnt_r < (bit_val ? HIGH_1 : HIGH_0));

endmodule

// File: rtl/ws2812_stream_tx.sv
// ----------------------------------------------------------------------------
// ws2812_stream_tx
// Return-to-zero encoder for WS2812-class LED chains. Pixels arrive on a
// valid/ready stream, are sent MSB-first with programmable bit timing and
// every frame is closed by a low latch gap.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   pix_valid   : pixel available          pix_ready : pixel accepted this cycle
//   pix_data    : pixel, MSB sent first    pix_last  : last pixel of the frame
//   abort       : abandon the current frame and go to the latch gap
//   rz_out      : registered line output (inverted when INVERT = 1)
//   busy        : encoder not idle
//   frame_done  : pulse in the last cycle of a latch gap that closed a frame
//   underrun    : pulse in the pixel-boundary cycle when the stream starved
// ----------------------------------------------------------------------------
module ws2812_stream_tx
   import ws2812_pkg::*;
#(
   parameter int BITS    = DEF_BITS,
   parameter int T_BIT   = DEF_T_BIT,
   parameter int T0H     = DEF_T0H,
   parameter int T1H     = DEF_T1H,
   parameter int T_RESET = DEF_T_RESET,
   parameter bit INVERT  = 1'b0
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pix_valid,
   output logic            pix_ready,
   input  logic [BITS-1:0] pix_data,
   input  logic            pix_last,
   input  logic            abort,
   output logic            rz_out,
   output logic            busy,
   output logic            frame_done,
   output logic            underrun
);

   localparam int IDX_W   = cnt_width(BITS);
   localparam int LATCH_W = cnt_width(T_RESET);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(BITS - 1);
   localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(T_RESET - 1);

   generate
      if (!(BITS >= 1 && T0H >= 1 && T0H < T1H && T1H < T_BIT && T_RESET >= 1)) begin : g_param_check
         $error("ws2812_stream_tx: illegal BITS/T0H/T1H/T_BIT/T_RESET combination");
      end
   endgenerate

   ws_state_e          state_r,     state_nx_s;
   logic [LATCH_W-1:0] latch_cnt_r, latch_cnt_nx_s;
   logic [IDX_W-1:0]   bit_idx_r,   bit_idx_nx_s;
   logic [BITS-1:0]    shreg_r,     shreg_nx_s;
   logic               last_q_r,    last_q_nx_s;
   logic               flag_r,      flag_nx_s;
   logic               rz_out_r;
   logic               busy_r;
   logic               frame_done_r;

   logic cell_end_s;
   logic level_s;
   logic run_s;
   logic boundary_s;
   logic pix_ready_s;
   logic hs_s;
   logic line_s;
   logic frame_done_nx_s;

   // The timer only runs during an un-aborted SEND cycle, so it sits at 0 when a pixel loads.
   assign run_s = (state_r == SEND) && !abort;

   rz_bit_timer #(
      .T_BIT (T_BIT),
      .T0H   (T0H),
      .T1H   (T1H)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run_s),
      .bit_val  (shreg_r[BITS-1]),
      .cell_end (cell_end_s),
      .level    (level_s)
   );

   // Last cycle of the last bit of the current pixel.
   assign boundary_s  = (state_r == SEND) && cell_end_s && (bit_idx_r == IDX_LAST);
   // Abort gates ready so a simultaneous offer is never consumed.
   assign pix_ready_s = ((state_r == IDLE) || (boundary_s && !last_q_r)) && !abort;
   assign hs_s        = pix_valid && pix_ready_s;
   assign line_s      = run_s && level_s;

   // Next-state, datapath and frame-flag logic.
   always_comb begin
      state_nx_s     = state_r;
      latch_cnt_nx_s = latch_cnt_r;
      bit_idx_nx_s   = bit_idx_r;
      shreg_nx_s     = shreg_r;
      last_q_nx_s    = last_q_r;
      flag_nx_s      = flag_r;
      case (state_r)
         LATCH: begin
            if (latch_cnt_r == LATCH_LAST) begin
               state_nx_s     = IDLE;
               latch_cnt_nx_s = '0;
               flag_nx_s      = 1'b0;
            end else begin
               latch_cnt_nx_s = latch_cnt_r + LATCH_W'(1);
            end
         end
         IDLE: begin
            if (abort) begin
               state_nx_s     = LATCH;
               latch_cnt_nx_s = '0;
            end else if (hs_s) begin
               state_nx_s   = SEND;
               shreg_nx_s   = pix_data;
               last_q_nx_s  = pix_last;
               bit_idx_nx_s = '0;
            end else begin
               state_nx_s = IDLE;
            end
         end
         SEND: begin
            if (abort) begin
               state_nx_s     = LATCH;
               latch_cnt_nx_s = '0;
               flag_nx_s      = 1'b1;
            end else if (cell_end_s) begin
               if (bit_idx_r == IDX_LAST) begin
                  if (last_q_r) begin
                     state_nx_s     = LATCH;
                     latch_cnt_nx_s = '0;
                     flag_nx_s      = 1'b1;
                  end else if (hs_s) begin
                     shreg_nx_s   = pix_data;
                     last_q_nx_s  = pix_last;
                     bit_idx_nx_s = '0;
                  end else begin
                     // Starved mid-frame: terminate the partial frame with a latch gap.
                     state_nx_s     = LATCH;
                     latch_cnt_nx_s = '0;
                     flag_nx_s      = 1'b1;
                  end
               end else begin
                  shreg_nx_s   = shreg_r << 1'b1;
                  bit_idx_nx_s = bit_idx_r + IDX_W'(1);
               end
            end else begin
               state_nx_s = SEND;
            end
         end
         default: begin
            state_nx_s     = LATCH;
            latch_cnt_nx_s = '0;
            flag_nx_s      = 1'b0;
         end
      endcase
   end

   // frame_done is registered one cycle ahead so it is high during the final LATCH cycle.
   assign frame_done_nx_s = (state_nx_s == LATCH) && (latch_cnt_nx_s == LATCH_LAST) && flag_nx_s;

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= LATCH;
         latch_cnt_r  <= '0;
         bit_idx_r    <= '0;
         shreg_r      <= '0;
         last_q_r     <= 1'b0;
         flag_r       <= 1'b0;
         rz_out_r     <= INVERT;
         busy_r       <= 1'b1;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         latch_cnt_r  <= latch_cnt_nx_s;
         bit_idx_r    <= bit_idx_nx_s;
         shreg_r      <= shreg_nx_s;
         last_q_r     <= last_q_nx_s;
         flag_r       <= flag_nx_s;
         rz_out_r     <= line_s ^ INVERT;
         busy_r       <= (state_nx_s != IDLE);
         frame_done_r <= frame_done_nx_s;
      end
   end

   assign pix_ready  = pix_ready_s;
   assign rz_out     = rz_out_r;
   assign busy       = busy_r;
   assign frame_done = frame_done_r;
   assign underrun   = boundary_s && !last_q_r && !pix_valid && !abort;

endmodule

// File: tb/tb_ws2812_stream_tx.sv
// ----------------------------------------------------------------------------
// tb_ws2812_stream_tx
// Two encoders (INVERT = 0 and INVERT = 1) share one stimulus stream. A
// per-cycle table of inputs and expected outputs is planned up front from
// frame-level timing arithmetic (handshake cycle, pixel period, latch gap),
// then applied and compared cycle by cycle. A final hand-written sequence
// covers asynchronous reset in the middle of a bit.
// ----------------------------------------------------------------------------
module tb_ws2812_stream_tx;

   localparam int BITS    = 8;
   localparam int T_BIT   = 10;
   localparam int T0H     = 3;
   localparam int T1H     = 7;
   localparam int T_RESET = 20;
   localparam int P       = BITS * T_BIT;
   localparam int NCYC    = 10000;

   typedef struct {
      logic            vld;
      logic [BITS-1:0] dat;
      logic            lst;
      logic            abt;
      logic            rz;
      logic            rdy;
      logic            busy;
      logic            fd;
      logic            ur;
   } vec_t;

   logic clk;
   logic rst_n;
   logic pix_valid;
   logic [BITS-1:0] pix_data;
   logic pix_last;
   logic abort;
   logic pix_ready, rz_out, busy, frame_done, underrun;
   logic pix_ready_i, rz_out_i, busy_i, frame_done_i, underrun_i;

   vec_t tbl [NCYC];
   logic [BITS-1:0] fpix [3];
   int t;
   int n_checks;
   int n_fail;

   ws2812_stream_tx #(
      .BITS(BITS), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RESET(T_RESET), .INVERT(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_data(pix_data), .pix_last(pix_last), .abort(abort), .rz_out(rz_out),
      .busy(busy), .frame_done(frame_done), .underrun(underrun)
   );

   ws2812_stream_tx #(
      .BITS(BITS), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RESET(T_RESET), .INVERT(1'b1)
   ) dut_inv (
      .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_ready(pix_ready_i),
      .pix_data(pix_data), .pix_last(pix_last), .abort(abort), .rz_out(rz_out_i),
      .busy(busy_i), .frame_done(frame_done_i), .underrun(underrun_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int cyc, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   // Ideal line level 'off' cycles into a pixel (pre-inversion).
   function automatic logic rz_of(input logic [BITS-1:0] px, input int off);
      int b;
      logic v;
      b = off / T_BIT;
      v = px[BITS-1-b];
      return ((off % T_BIT) < (v ? T1H : T0H));
   endfunction

   task automatic plan_idle(input int delay);
      for (int c = t; c < t + delay; c++) begin
         tbl[c].rdy  = 1'b1;
         tbl[c].busy = 1'b0;
      end
      t = t + delay;
   endtask

   // Latch gap of T_RESET cycles from 'start'; abort and valid are noise here.
   task automatic plan_latch(input int start, input bit with_fd);
      for (int c = start; c < start + T_RESET; c++) begin
         tbl[c].busy = 1'b1;
         tbl[c].rdy  = 1'b0;
         tbl[c].vld  = 1'($urandom % 2);
         tbl[c].abt  = ($urandom % 4 == 0);
      end
      tbl[start + T_RESET - 1].fd = with_fd;
      t = start + T_RESET;
   endtask

   // Frame of n pixels from fpix, handshake 'delay' cycles after IDLE is reached.
   task automatic plan_frame(input int delay, input int n, input bit starve, input bit hold);
      int h;
      int b;
      plan_idle(delay);
      h = t;
      tbl[h].rdy  = 1'b1;
      tbl[h].busy = 1'b0;
      tbl[h].vld  = 1'b1;
      tbl[h].dat  = fpix[0];
      tbl[h].lst  = (n == 1) && !starve;
      for (int c = h + 1; c <= h + n * P; c++) begin
         tbl[c].busy = 1'b1;
         tbl[c].vld  = hold ? 1'b1 : 1'($urandom % 2);
      end
      for (int i = 1; i < n; i++) begin
         b = h + i * P;
         tbl[b].rdy = 1'b1;
         tbl[b].vld = 1'b1;
         tbl[b].dat = fpix[i];
         tbl[b].lst = (i == n - 1) && !starve;
      end
      if (starve) begin
         b = h + n * P;
         tbl[b].rdy = 1'b1;
         tbl[b].vld = 1'b0;
         tbl[b].ur  = 1'b1;
      end
      for (int j = 0; j < n * P; j++) begin
         tbl[h + 2 + j].rz = rz_of(fpix[j / P], j % P);
      end
      plan_latch(h + n * P + 1, 1'b1);
   endtask

   // Single pixel aborted at bit 'abit', cell count 'acnt'; a handshake is offered in the abort cycle.
   task automatic plan_abort(input int delay, input logic [BITS-1:0] px, input int abit, input int acnt);
      int h;
      int a;
      plan_idle(delay);
      h = t;
      a = h + 1 + abit * T_BIT + acnt;
      tbl[h].rdy  = 1'b1;
      tbl[h].busy = 1'b0;
      tbl[h].vld  = 1'b1;
      tbl[h].dat  = px;
      tbl[h].lst  = 1'b0;
      for (int c = h + 1; c <= a; c++) begin
         tbl[c].busy = 1'b1;
         tbl[c].vld  = 1'($urandom % 2);
      end
      for (int c = h + 2; c <= a; c++) begin
         tbl[c].rz = rz_of(px, c - h - 2);
      end
      tbl[a].abt = 1'b1;
      tbl[a].vld = 1'b1;
      plan_latch(a + 1, 1'b1);
   endtask

   // Abort while idle with a pixel on offer: refused, latch gap, no frame_done.
   task automatic plan_idle_abort(input int delay);
      plan_idle(delay);
      tbl[t].busy = 1'b0;
      tbl[t].rdy  = 1'b0;
      tbl[t].vld  = 1'b1;
      tbl[t].abt  = 1'b1;
      plan_latch(t + 1, 1'b0);
   endtask

   task automatic check_outputs(input int c, input vec_t v);
      chk("rz_out",       c, rz_out,       v.rz);
      chk("pix_ready",    c, pix_ready,    v.rdy);
      chk("busy",         c, busy,         v.busy);
      chk("frame_done",   c, frame_done,   v.fd);
      chk("underrun",     c, underrun,     v.ur);
      chk("inv_rz_out",   c, rz_out_i,     ~v.rz);
      chk("inv_ready",    c, pix_ready_i,  v.rdy);
      chk("inv_busy",     c, busy_i,       v.busy);
      chk("inv_done",     c, frame_done_i, v.fd);
      chk("inv_underrun", c, underrun_i,   v.ur);
   endtask

   initial begin
      int kind;
      int n;
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      pix_valid = 1'b0;
      pix_data  = '0;
      pix_last  = 1'b0;
      abort     = 1'b0;

      for (int c = 0; c < NCYC; c++) begin
         tbl[c].vld  = 1'b0;
         tbl[c].dat  = BITS'($urandom);
         tbl[c].lst  = 1'($urandom % 2);
         tbl[c].abt  = 1'b0;
         tbl[c].rz   = 1'b0;
         tbl[c].rdy  = 1'b0;
         tbl[c].busy = 1'b1;
         tbl[c].fd   = 1'b0;
         tbl[c].ur   = 1'b0;
      end

      // Reset latch gap, then the directed frames, then random traffic.
      plan_latch(1, 1'b0);
      fpix[0] = 8'hA5;
      plan_frame(2, 1, 1'b0, 1'b0);
      fpix[0] = 8'hFF; fpix[1] = 8'h00; fpix[2] = 8'h81;
      plan_frame(1, 3, 1'b0, 1'b1);
      fpix[0] = 8'h0F;
      plan_frame(0, 1, 1'b1, 1'b0);
      plan_abort(2, 8'hC3, 3, 2);
      plan_idle_abort(1);
      while (t < NCYC - 400) begin
         kind = int'($urandom % 8);
         if (kind == 0) begin
            plan_abort(int'($urandom % 4), BITS'($urandom), int'($urandom % BITS),
                       int'($urandom % (T_BIT - 1)));
         end else if (kind == 1) begin
            plan_idle_abort(int'($urandom % 4));
         end else begin
            n = 1 + int'($urandom % 3);
            for (int i = 0; i < 3; i++) fpix[i] = BITS'($urandom);
            plan_frame(int'($urandom % 4), n, ($urandom % 4 == 0), 1'($urandom % 2));
         end
      end

      // Reset state, sampled while rst_n is still low.
      repeat (3) @(posedge clk);
      @(negedge clk);
      pix_valid = 1'b1;
      #1;
      chk("reset_rz",    0, rz_out,    1'b0);
      chk("reset_rz_inv",0, rz_out_i,  1'b1);
      chk("reset_ready", 0, pix_ready, 1'b0);
      chk("reset_busy",  0, busy,      1'b1);
      chk("reset_done",  0, frame_done,1'b0);

      rst_n = 1'b1;
      for (int c = 1; c < t; c++) begin
         pix_valid = tbl[c].vld;
         pix_data  = tbl[c].dat;
         pix_last  = tbl[c].lst;
         abort     = tbl[c].abt;
         #1;
         check_outputs(c, tbl[c]);
         @(posedge clk);
         #1;
      end

      // Encoder is idle: start a pixel, then hit rst_n in the middle of its first high phase.
      pix_valid = 1'b1;
      pix_data  = 8'hFF;
      pix_last  = 1'b1;
      abort     = 1'b0;
      #1;
      chk("hs_ready", t, pix_ready, 1'b1);
      chk("hs_busy",  t, busy,      1'b0);
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      #1;
      chk("send_busy",  t + 1, busy,   1'b1);
      chk("first_low",  t + 1, rz_out, 1'b0);
      @(posedge clk);
      #1;
      chk("first_high", t + 2, rz_out, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_rz",     0, rz_out,    1'b0);
      chk("async_rz_inv", 0, rz_out_i,  1'b1);
      chk("async_busy",   0, busy,      1'b1);
      chk("async_ready",  0, pix_ready, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= T_RESET + 1; k++) begin
         #1;
         chk("rerst_rz",    k, rz_out,     1'b0);
         chk("rerst_ready", k, pix_ready,  (k == T_RESET + 1));
         chk("rerst_done",  k, frame_done, 1'b0);
         @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
